seq_det_prog: RTL

Programmable serial-bit sequence detector. Generalises the fixed 3-bit Moore detector to a run-time pattern of up to MAX_LEN bits, with selectable overlapping or non-overlapping detection, an input-enable and a saturating match counter. It sits on a single-bit serial stream in the PBL sequence-detector family. The output is Moore-style: it is a function of registered state only.

---
 rtl/seq_det_prog_if.sv | 28 ++
 rtl/seq_det_prog.sv | 96 +++++++++
 2 files changed

// File: rtl/seq_det_prog_if.sv
// Signal bundle for the programmable sequence detector: serial/config inputs
// and detect/status outputs, named from the detector's point of view.
interface seq_det_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
);
    logic               i_en;
    logic               i_x;
    logic               i_cfg_wr;
    logic [MAX_LEN-1:0] i_cfg_pat;
    logic [LEN_W-1:0]   i_cfg_len;
    logic               i_cfg_ovl;
    logic               o_y;
    logic [CNT_W-1:0]   o_match_cnt;
    logic               o_cnt_sat;
    logic               o_cfg_err;

    modport master (
        output i_en, i_x, i_cfg_wr, i_cfg_pat, i_cfg_len, i_cfg_ovl,
        input  o_y, o_match_cnt, o_cnt_sat, o_cfg_err
    );

    modport slave (
        input  i_en, i_x, i_cfg_wr, i_cfg_pat, i_cfg_len, i_cfg_ovl,
        output o_y, o_match_cnt, o_cnt_sat, o_cfg_err
    );
endinterface

// File: rtl/seq_det_prog.sv
// Programmable serial-bit sequence detector: shift history compared under a
// length mask, overlap/non-overlap restart, saturating match counter.
module seq_det_prog #(
    parameter int                 MAX_LEN = 8,
    parameter int                 LEN_W   = 4,
    parameter int                 CNT_W   = 8,
    parameter logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(5),
    parameter int                 RST_LEN = 3,
    parameter logic               RST_OVL = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    seq_det_prog_if.slave bus
);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic             RST_ERR   = (RST_LEN < 1) || (RST_LEN > MAX_LEN);

    logic [MAX_LEN-1:0] r_pat, r_hist;
    logic [LEN_W-1:0]   r_len, r_fill;
    logic               r_ovl, r_y, r_err;
    logic [CNT_W-1:0]   r_cnt;

    logic [MAX_LEN-1:0] w_pat_n, w_hist_n, w_hist_sh, w_mask;
    logic [LEN_W-1:0]   w_len_n, w_fill_n, w_fill_inc;
    logic               w_ovl_n, w_y_n, w_err_n, w_hit;
    logic [CNT_W-1:0]   w_cnt_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pat  <= RST_PAT;
            r_len  <= LEN_W'(RST_LEN);
            r_ovl  <= RST_OVL;
            r_hist <= '0;
            r_fill <= '0;
            r_y    <= 1'b0;
            r_cnt  <= '0;
            r_err  <= RST_ERR;
        end else begin
            r_pat  <= w_pat_n;
            r_len  <= w_len_n;
            r_ovl  <= w_ovl_n;
            r_hist <= w_hist_n;
            r_fill <= w_fill_n;
            r_y    <= w_y_n;
            r_cnt  <= w_cnt_n;
            r_err  <= w_err_n;
        end
    end

    always_comb begin
        w_hist_sh  = {r_hist[MAX_LEN-2:0], bus.i_x};
        w_fill_inc = (r_fill >= MAX_LEN_L) ? MAX_LEN_L : r_fill + 1'b1;
        w_mask     = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (LEN_W'(i) < r_len);
        end
        // Bits above len-1 are don't-care, so only the masked window is compared.
        w_hit = !r_err && (w_fill_inc >= r_len) &&
                (((w_hist_sh ^ r_pat) & w_mask) == '0);

        w_pat_n  = r_pat;
        w_len_n  = r_len;
        w_ovl_n  = r_ovl;
        w_hist_n = r_hist;
        w_fill_n = r_fill;
        w_y_n    = r_y;
        w_cnt_n  = r_cnt;
        w_err_n  = r_err;

        if (bus.i_cfg_wr) begin
            w_pat_n  = bus.i_cfg_pat;
            w_len_n  = bus.i_cfg_len;
            w_ovl_n  = bus.i_cfg_ovl;
            w_hist_n = '0;
            w_fill_n = '0;
            w_y_n    = 1'b0;
            w_cnt_n  = '0;
            w_err_n  = (bus.i_cfg_len == '0) || (bus.i_cfg_len > MAX_LEN_L);
        end else if (bus.i_en) begin
            w_hist_n = w_hist_sh;
            w_y_n    = w_hit;
            // Non-overlap restarts the fill so the next match needs len fresh bits.
            w_fill_n = (w_hit && !r_ovl) ? '0 : w_fill_inc;
            if (w_hit && !(&r_cnt)) begin
                w_cnt_n = r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        bus.o_y         = r_y;
        bus.o_match_cnt = r_cnt;
        bus.o_cnt_sat   = &r_cnt;
        bus.o_cfg_err   = r_err;
    end
endmodule
